// File: rtl/r2sdf_butterfly_if.sv
// r2sdf_butterfly_if: sample/twiddle bus into the radix-2 SDF butterfly stage
// and the twiddled output sample back out.
//   master : upstream side (ROM stage / bench), drives sample, mode code, twiddle
//   slave  : butterfly stage, consumes the above and drives out_valid/dout
interface r2sdf_butterfly_if #(
  parameter int DW = 24,
  parameter int TW = 24
);
  logic                 in_valid;
  logic signed [DW-1:0] din_r;
  logic signed [DW-1:0] din_i;
  logic        [1:0]    state;
  logic signed [TW-1:0] w_r;
  logic signed [TW-1:0] w_i;
  logic                 out_valid;
  logic signed [DW-1:0] dout_r;
  logic signed [DW-1:0] dout_i;

  modport master (
    output in_valid, din_r, din_i, state, w_r, w_i,
    input  out_valid, dout_r, dout_i
  );

  modport slave (
    input  in_valid, din_r, din_i, state, w_r, w_i,
    output out_valid, dout_r, dout_i
  );
endinterface

// File: rtl/r2sdf_butterfly.sv
// r2sdf_butterfly: radix-2 single-path delay-feedback butterfly stage.
// First-half samples are parked in a DEPTH-deep complex feedback delay line;
// second-half samples form (d+x)/2 (emitted) and (d-x)/2 (fed back). Every
// candidate is multiplied by the same-cycle twiddle and registered.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of r2sdf_butterfly_if
//           (in_valid, din_r/i, state, w_r/i in; out_valid, dout_r/i out)
// state: 0 idle/fill, 1 delay phase, 2 butterfly phase, 3 treated as idle.
module r2sdf_butterfly #(
  parameter int DW    = 24,
  parameter int TW    = 24,
  parameter int FRAC  = 8,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  r2sdf_butterfly_if.slave     bus
);
  localparam int PW = DW + TW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_BFLY  = 2'd2,
    ST_RSVD  = 2'd3
  } mode_e;

  mode_e mode;
  assign mode = mode_e'(bus.state);

  // Delay line: index 0 newest, DEPTH-1 oldest (head).
  logic [DEPTH-1:0][DW-1:0] dl_r_q, dl_r_d, dl_i_q, dl_i_d;
  logic                     primed_q, primed_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DW-1:0]     dout_r_q, dout_r_d, dout_i_q, dout_i_d;

  logic signed [DW-1:0] head_r, head_i;
  logic signed [DW:0]   sum_r, sum_i, dif_r, dif_i;
  logic signed [DW-1:0] push_r, push_i, c_r, c_i;
  logic                 shift_en;

  // Twiddle product terms at full precision.
  logic signed [PW-1:0] cr_x, ci_x, wr_x, wi_x, prod_r, prod_i, shr_r, shr_i;

  assign head_r = dl_r_q[DEPTH-1];
  assign head_i = dl_i_q[DEPTH-1];

  // One extra bit so the sum/difference never overflows before halving.
  assign sum_r = (DW+1)'(head_r) + (DW+1)'(bus.din_r);
  assign sum_i = (DW+1)'(head_i) + (DW+1)'(bus.din_i);
  assign dif_r = (DW+1)'(head_r) - (DW+1)'(bus.din_r);
  assign dif_i = (DW+1)'(head_i) - (DW+1)'(bus.din_i);

  always_comb begin
    shift_en = 1'b0;
    push_r   = '0;
    push_i   = '0;
    c_r      = '0;
    c_i      = '0;
    unique case (mode)
      ST_DELAY: begin
        shift_en = 1'b1;
        push_r   = bus.din_r;
        push_i   = bus.din_i;
        c_r      = head_r;
        c_i      = head_i;
      end
      ST_BFLY: begin
        shift_en = 1'b1;
        // Taking bits [DW:1] is the arithmetic >>>1 truncated to DW bits.
        push_r   = dif_r[DW:1];
        push_i   = dif_i[DW:1];
        c_r      = sum_r[DW:1];
        c_i      = sum_i[DW:1];
      end
      ST_IDLE, ST_RSVD: ;
      default: ;
    endcase
  end

  always_comb begin
    cr_x   = PW'(c_r);
    ci_x   = PW'(c_i);
    wr_x   = PW'(bus.w_r);
    wi_x   = PW'(bus.w_i);
    prod_r = cr_x * wr_x - ci_x * wi_x;
    prod_i = cr_x * wi_x + ci_x * wr_x;
    shr_r  = prod_r >>> FRAC;
    shr_i  = prod_i >>> FRAC;
  end

  always_comb begin
    dl_r_d = dl_r_q;
    dl_i_d = dl_i_q;
    if (shift_en) begin
      dl_r_d[0] = push_r;
      dl_i_d[0] = push_i;
      for (int k = 1; k < DEPTH; k++) begin
        dl_r_d[k] = dl_r_q[k-1];
        dl_i_d[k] = dl_i_q[k-1];
      end
    end
    primed_d    = primed_q | (mode == ST_BFLY);
    // Delay-phase heads are only real differences once a butterfly has run.
    out_valid_d = (mode == ST_BFLY) | ((mode == ST_DELAY) & primed_q);
    // Wraps on overflow: plain truncation to the low DW bits.
    dout_r_d    = shr_r[DW-1:0];
    dout_i_d    = shr_i[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_r_q      <= '0;
      dl_i_q      <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      dout_r_q    <= '0;
      dout_i_q    <= '0;
    end else begin
      dl_r_q      <= dl_r_d;
      dl_i_q      <= dl_i_d;
      primed_q    <= primed_d;
      out_valid_q <= out_valid_d;
      dout_r_q    <= dout_r_d;
      dout_i_q    <= dout_i_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout_r    = dout_r_q;
  assign bus.dout_i    = dout_i_q;
endmodule

// File: tb/tb_r2sdf_butterfly.sv
// tb_r2sdf_butterfly: directed vectors for the radix-2 SDF butterfly stage.
// The driver pushes hand-computed expected outputs into a queue; a monitor on
// the falling edge pops and compares whenever out_valid is high.
module tb_r2sdf_butterfly;
  localparam int DW = 24;
  localparam int TW = 24;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  logic signed [DW-1:0] exp_r_q[$];
  logic signed [DW-1:0] exp_i_q[$];

  r2sdf_butterfly_if #(.DW(DW), .TW(TW)) bus ();

  r2sdf_butterfly #(.DW(DW), .TW(TW), .FRAC(8), .DEPTH(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every presented output must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      n_chk++;
      if (exp_r_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got %0d,%0d expected no valid output",
                 int'(bus.dout_r), int'(bus.dout_i));
      end else begin
        logic signed [DW-1:0] er, ei;
        er = exp_r_q.pop_front();
        ei = exp_i_q.pop_front();
        if (bus.dout_r !== er || bus.dout_i !== ei) begin
          n_fail++;
          $display("FAIL dout: got %0d,%0d expected %0d,%0d",
                   int'(bus.dout_r), int'(bus.dout_i), int'(er), int'(ei));
        end
      end
    end
  end

  // One cycle: present inputs, optionally register the expected output.
  task automatic step(input int st, input int xr, input int xi,
                      input int wr, input int wi,
                      input bit ev, input int er, input int ei);
    bus.state    = st[1:0];
    bus.in_valid = (st != 0);
    bus.din_r    = xr[DW-1:0];
    bus.din_i    = xi[DW-1:0];
    bus.w_r      = wr[TW-1:0];
    bus.w_i      = wi[TW-1:0];
    if (ev) begin
      exp_r_q.push_back(er[DW-1:0]);
      exp_i_q.push_back(ei[DW-1:0]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 256, 0, 1'b0, 0, 0);
  endtask

  task automatic drained(input string name);
    idle(2);
    chk(name, exp_r_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_dout_r", int'(bus.dout_r), 0);
    chk("rst_dout_i", int'(bus.dout_i), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b1;
    bus.state = 2'd0; bus.in_valid = 1'b0;
    bus.din_r = '0; bus.din_i = '0; bus.w_r = 24'sd256; bus.w_i = '0;
    #2;
    do_reset();

    // Idle after reset: outputs stay at zero.
    idle(4);
    chk("idle_valid", int'(bus.out_valid), 0);
    chk("idle_dout_r", int'(bus.dout_r), 0);
    chk("idle_dout_i", int'(bus.dout_i), 0);

    // Basic butterfly then drain of the two stored differences.
    step(1, 4, 0, 256, 0, 1'b0, 0, 0);
    step(1, 8, 0, 256, 0, 1'b0, 0, 0);
    step(2, 2, 0, 256, 0, 1'b1, 3, 0);
    step(2, 6, 0, 256, 0, 1'b1, 7, 0);
    step(1, 0, 0, 256, 0, 1'b1, 1, 0);
    step(1, 0, 0, 256, 0, 1'b1, 1, 0);
    // Twiddle -j on 3+j0 and 0+j5 (delay line holds zeros).
    step(2, 6, 0,  0, -256, 1'b1, 0, -3);
    step(2, 0, 10, 0, -256, 1'b1, 5, 0);
    // Heads now -3+j0 then 0-j5: negative arithmetic shift, half twiddle.
    step(2, 0, 0, 256, 0, 1'b1, -2, 0);
    step(2, 14, 5, 128, 0, 1'b1, 3, 0);
    // Drain: stored -2+j0, then (-14>>>1, -10>>>1) = -7-j5.
    step(1, 0, 0, 256, 0, 1'b1, -2, 0);
    step(1, 0, 0, 256, 0, 1'b1, -7, -5);
    drained("drain1");

    // Reset mid-stream while out_valid is high: immediate clear.
    step(2, 6, 0, 256, 0, 1'b0, 0, 0);
    chk("pre_rst_valid", int'(bus.out_valid), 1);
    do_reset();
    // Delay line cleared: head is 0, so sum = x/2 and diff = -x/2.
    step(2, 2, 2, 256, 0, 1'b1, 1, 1);
    drained("post_rst");

    // Unprimed after reset, with an idle cycle between the fill cycles.
    do_reset();
    step(1, 4, 0, 256, 0, 1'b0, 0, 0);
    step(0, 99, 99, 256, 0, 1'b0, 0, 0);
    step(1, 8, 0, 256, 0, 1'b0, 0, 0);
    step(2, 2, 0, 256, 0, 1'b1, 3, 0);
    step(2, 6, 0, 256, 0, 1'b1, 7, 0);
    step(3, 50, 50, 256, 0, 1'b0, 0, 0);
    step(1, 0, 0, 256, 0, 1'b1, 1, 0);
    step(1, 0, 0, 256, 0, 1'b1, 1, 0);
    drained("drain2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
